// File: rtl/tm_qm_assoc_lookup.sv
// Queue-association lookup stage: issues one memory read per accepted descriptor and pairs the
// in-order association replies with their descriptors for downstream consumption.

`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef QUEUE_ASSOCIATION_NBITS
`define QUEUE_ASSOCIATION_NBITS 8
`endif

module tm_qm_assoc_lookup #(
  parameter int unsigned DESC_NBITS = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enq_valid,
  input  logic [`FIRST_LVL_QUEUE_ID_NBITS-1:0] enq_qid,
  input  logic [DESC_NBITS-1:0]                enq_desc,
  output logic                                 enq_ready,
  output logic                                 queue_association_rd,
  output logic [`FIRST_LVL_QUEUE_ID_NBITS-1:0] queue_association_raddr,
  input  logic                                 queue_association_ack,
  input  logic [`QUEUE_ASSOCIATION_NBITS-1:0]  queue_association_rdata,
  output logic                                 out_valid,
  output logic [`FIRST_LVL_QUEUE_ID_NBITS-1:0] out_qid,
  output logic [DESC_NBITS-1:0]                out_desc,
  output logic [`QUEUE_ASSOCIATION_NBITS-1:0]  out_assoc,
  input  logic                                 out_ready,
  output logic                                 err_spurious_ack,
  output logic [15:0]                          lookup_cnt
);

  localparam int unsigned QidW  = `FIRST_LVL_QUEUE_ID_NBITS;
  localparam int unsigned AsscW = `QUEUE_ASSOCIATION_NBITS;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned EntW  = QidW + DESC_NBITS;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0] One    = (PtrW + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]      dwr_q, drd_q, rwr_q, rrd_q;
  logic [PtrW:0]      credits_q, credits_d, outst_q, outst_d;
  logic               rd_q;
  logic [QidW-1:0]    raddr_q;
  logic               err_q;
  logic [15:0]        cnt_q;
  logic [EntW-1:0]    dmem [DEPTH];
  logic [AsscW-1:0]   rmem [DEPTH];
  logic [EntW-1:0]    dhead;
  logic               accept, pop, ack_ok;

  assign enq_ready = (credits_q < DepthC);
  assign accept    = enq_valid & enq_ready;
  assign out_valid = (rrd_q != rwr_q);
  assign pop       = out_valid & out_ready;
  assign ack_ok    = queue_association_ack & (outst_q != '0);

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q + One;
    end else if (pop && !accept) begin
      credits_d = credits_q - One;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (accept && !ack_ok) begin
      outst_d = outst_q + One;
    end else if (ack_ok && !accept) begin
      outst_d = outst_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwr_q     <= '0;
      drd_q     <= '0;
      rwr_q     <= '0;
      rrd_q     <= '0;
      credits_q <= '0;
      outst_q   <= '0;
      rd_q      <= 1'b0;
      raddr_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      credits_q <= credits_d;
      outst_q   <= outst_d;
      rd_q      <= accept;
      if (accept) begin
        dwr_q   <= dwr_q + One;
        raddr_q <= enq_qid;
      end
      if (ack_ok) begin
        rwr_q <= rwr_q + One;
      end
      if (pop) begin
        drd_q <= drd_q + One;
        rrd_q <= rrd_q + One;
      end
      if (queue_association_ack && (outst_q == '0)) begin
        err_q <= 1'b1;
      end
      if (rd_q) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: heads are only exposed while out_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      dmem[dwr_q[PtrW-1:0]] <= {enq_qid, enq_desc};
    end
    if (ack_ok) begin
      rmem[rwr_q[PtrW-1:0]] <= queue_association_rdata;
    end
  end

  assign dhead = dmem[drd_q[PtrW-1:0]];

  assign out_qid   = out_valid ? dhead[EntW-1:DESC_NBITS]    : '0;
  assign out_desc  = out_valid ? dhead[DESC_NBITS-1:0]       : '0;
  assign out_assoc = out_valid ? rmem[rrd_q[PtrW-1:0]]       : '0;

  assign queue_association_rd    = rd_q;
  assign queue_association_raddr = raddr_q;
  assign err_spurious_ack        = err_q;
  assign lookup_cnt              = cnt_q;

endmodule

// File: tb/tb_tm_qm_assoc_lookup.sv
// Directed bench for tm_qm_assoc_lookup with an in-order association memory responder.

`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef QUEUE_ASSOCIATION_NBITS
`define QUEUE_ASSOCIATION_NBITS 8
`endif

module tb_tm_qm_assoc_lookup;
  localparam int QW    = `FIRST_LVL_QUEUE_ID_NBITS;
  localparam int AW    = `QUEUE_ASSOCIATION_NBITS;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enq_valid;
  logic [QW-1:0] enq_qid;
  logic [DW-1:0] enq_desc;
  logic          enq_ready;
  logic          rd;
  logic [QW-1:0] raddr;
  logic          ack;
  logic [AW-1:0] rdata;
  logic          out_valid;
  logic [QW-1:0] out_qid;
  logic [DW-1:0] out_desc;
  logic [AW-1:0] out_assoc;
  logic          out_ready;
  logic          err;
  logic [15:0]   lookup_cnt;

  tm_qm_assoc_lookup #(.DESC_NBITS(DW), .DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .enq_valid               (enq_valid),
    .enq_qid                 (enq_qid),
    .enq_desc                (enq_desc),
    .enq_ready               (enq_ready),
    .queue_association_rd    (rd),
    .queue_association_raddr (raddr),
    .queue_association_ack   (ack),
    .queue_association_rdata (rdata),
    .out_valid               (out_valid),
    .out_qid                 (out_qid),
    .out_desc                (out_desc),
    .out_assoc               (out_assoc),
    .out_ready               (out_ready),
    .err_spurious_ack        (err),
    .lookup_cnt              (lookup_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Ack latency counted from the accept cycle (2 = fastest legal reply).
  int lat   = 2;

  logic [AW-1:0] tab [1 << QW];

  typedef struct {
    int            due;
    logic [AW-1:0] d;
  } ack_t;
  ack_t pend[$];

  logic          resp_ack   = 1'b0;
  logic [AW-1:0] resp_rdata = '0;
  logic          man_ack;
  logic [AW-1:0] man_rdata;

  assign ack   = resp_ack | man_ack;
  assign rdata = man_ack ? man_rdata : resp_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  // Association memory model: in-order replies, fixed latency per scenario.
  always @(negedge clk) begin
    resp_ack   = 1'b0;
    resp_rdata = '0;
    if (rd === 1'b1) pend.push_back('{due: cyc + lat - 1, d: tab[raddr]});
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      resp_ack   = 1'b1;
      resp_rdata = pend[0].d;
      void'(pend.pop_front());
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b want=1", enq_ready); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", rd); end
    total++; if (raddr !== '0) begin bad++; $display("FAIL reset_raddr got=%h want=0", raddr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if ({out_qid, out_desc, out_assoc} !== '0) begin
      bad++; $display("FAIL reset_out_data got=%h/%h/%h want=0", out_qid, out_desc, out_assoc);
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (lookup_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", lookup_cnt); end
    rst_n = 1'b1;
  endtask

  // Called in the same negedge that releases reset: first accept in first cycle out of reset.
  task automatic test_single;
    lat = 3;
    enq_valid = 1'b1; enq_qid = 8'h05; enq_desc = 32'hCAFE0001;
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", enq_ready); end
    tick();
    enq_valid = 1'b0;
    total++;
    if (rd !== 1'b1 || raddr !== 8'h05) begin
      bad++; $display("FAIL single_rd got=%b/%h want=1/05", rd, raddr);
    end
    tick();
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL single_rd_pulse got=%b want=0", rd); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", out_valid); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_qid !== 8'h05 || out_desc !== 32'hCAFE0001 || out_assoc !== 8'h12)
    begin
      bad++;
      $display("FAIL single_out got=%b %h %h %h want=1 05 cafe0001 12",
               out_valid, out_qid, out_desc, out_assoc);
    end
    total++; if (lookup_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", lookup_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b want=0", out_valid); end
  endtask

  task automatic test_fill;
    lat = 2;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      enq_valid = 1'b1; enq_qid = QW'(i); enq_desc = 32'hD0000000 + i;
      total++;
      if (enq_ready !== (i <= DEPTH)) begin
        bad++; $display("FAIL fill_ready[%0d] got=%b want=%b", i, enq_ready, (i <= DEPTH));
      end
      tick();
    end
    enq_valid = 1'b0;
    repeat (6) tick();
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", enq_ready); end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_qid !== QW'(i) || out_desc !== 32'hD0000000 + i ||
          out_assoc !== tab[i]) begin
        bad++;
        $display("FAIL fill_out[%0d] got=%b %h %h %h want=1 %h %h %h", i, out_valid, out_qid,
                 out_desc, out_assoc, QW'(i), 32'hD0000000 + i, tab[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (i == 1) begin
        total++;
        if (enq_ready !== 1'b1) begin bad++; $display("FAIL fill_reopen got=%b want=1", enq_ready); end
      end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_stream;
    int sent = 0;
    int rx   = 0;
    lat = 2;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && rx < 100; c++) begin
      if (out_valid === 1'b1) begin
        total++;
        if (out_qid !== QW'(rx + 16) || out_desc !== 32'h50000000 + rx ||
            out_assoc !== tab[rx + 16]) begin
          bad++;
          $display("FAIL stream_out[%0d] got=%h %h %h want=%h %h %h", rx, out_qid, out_desc,
                   out_assoc, QW'(rx + 16), 32'h50000000 + rx, tab[rx + 16]);
        end
        rx++;
      end
      if (sent < 100) begin
        total++;
        if (enq_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", sent, enq_ready); end
        enq_valid = 1'b1; enq_qid = QW'(sent + 16); enq_desc = 32'h50000000 + sent;
        sent++;
      end else begin
        enq_valid = 1'b0;
      end
      tick();
    end
    enq_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (rx != 100) begin bad++; $display("FAIL stream_count got=%0d want=100", rx); end
    repeat (2) tick();
    total++; if (lookup_cnt !== 16'd105) begin bad++; $display("FAIL stream_cnt got=%0d want=105", lookup_cnt); end
  endtask

  task automatic test_spurious;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL spur_pre got=%b want=0", err); end
    man_ack = 1'b1; man_rdata = 8'h7F;
    tick();
    man_ack = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err got=%b want=1", err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL spur_valid got=%b want=0", out_valid); end
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL spur_ready got=%b want=1", enq_ready); end
    repeat (2) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b want=1", err); end
  endtask

  task automatic test_reset_midflight;
    bit seen_valid = 1'b0;
    lat = 6;
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_qid = QW'(8'h21 + i); enq_desc = 32'hBEEF0000 + i;
      tick();
    end
    enq_valid = 1'b0;
    total++;
    if (rd !== 1'b1 || raddr !== 8'h23) begin bad++; $display("FAIL mid_rd got=%b/%h want=1/23", rd, raddr); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (rd !== 1'b0 || raddr !== '0 || out_valid !== 1'b0 || out_qid !== '0) begin
      bad++; $display("FAIL mid_reset_out got=%b %h %b %h want=0 0 0 0", rd, raddr, out_valid, out_qid);
    end
    total++;
    if (err !== 1'b0 || lookup_cnt !== 16'd0 || enq_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_state got=%b %0d %b want=0 0 1", err, lookup_cnt, enq_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    total++; if (seen_valid) begin bad++; $display("FAIL mid_late_valid got=1 want=0"); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_late_err got=%b want=1", err); end
  endtask

  task automatic test_simultaneous;
    int k = 0;
    lat = 2;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_qid = QW'(8'h31 + i); enq_desc = 32'hA0000000 + i;
      tick();
    end
    // credits = DEPTH-1 here; accept, ack and pop all land on the next edge
    total++;
    if (enq_ready !== 1'b1 || out_valid !== 1'b1 || out_qid !== 8'h31) begin
      bad++; $display("FAIL sim_pre got=%b %b %h want=1 1 31", enq_ready, out_valid, out_qid);
    end
    enq_qid = 8'h34; enq_desc = 32'hA0000003; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (enq_ready !== 1'b1 || out_qid !== 8'h32) begin
      bad++; $display("FAIL sim_credits got=%b %h want=1 32", enq_ready, out_qid);
    end
    enq_qid = 8'h35; enq_desc = 32'hA0000004;
    tick();
    enq_valid = 1'b0;
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL sim_full got=%b want=0", enq_ready); end
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (out_valid === 1'b1) begin
        total++;
        if (out_qid !== QW'(8'h32 + k) || out_desc !== 32'hA0000001 + k ||
            out_assoc !== tab[8'h32 + k]) begin
          bad++;
          $display("FAIL sim_out[%0d] got=%h %h %h want=%h %h %h", k, out_qid, out_desc, out_assoc,
                   QW'(8'h32 + k), 32'hA0000001 + k, tab[8'h32 + k]);
        end
        out_ready = 1'b1;
        k++;
      end else begin
        out_ready = 1'b0;
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (k != 4) begin bad++; $display("FAIL sim_count got=%0d want=4", k); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sim_empty got=%b want=0", out_valid); end
    total++; if (lookup_cnt !== 16'd5) begin bad++; $display("FAIL sim_cnt got=%0d want=5", lookup_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_qid = '0; enq_desc = '0;
    out_ready = 1'b0; man_ack = 1'b0; man_rdata = '0;
    for (int i = 0; i < (1 << QW); i++) tab[i] = AW'(i * 7 + 3);
    tab[5] = 8'h12;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_spurious();
    test_reset_midflight();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
